tmds_deser_1to10: RTL and testbench

TMDS_DESER_1TO10 -- requirements
Module: tmds_deser_1to10

---
 rtl/tmds_rx_pkg.sv | 29 ++
 rtl/tmds_deser_1to10_if.sv | 25 ++
 rtl/tmds_lane_align.sv | 131 +++++++++++++
 rtl/tmds_deser_1to10.sv | 64 ++++++
 tb/tb_tmds_deser_1to10.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/tmds_rx_pkg.sv
// Shared constants, lane-state encoding and token check for the TMDS 1:10 deserializer.
package tmds_rx_pkg;

    localparam int NUM_LANES   = 3;
    localparam int SYM_W       = 10;
    localparam int HIST_W      = 20;
    localparam int OFFSET_W    = 4;
    localparam int NUM_OFFSETS = 10;
    localparam int CNT_W       = 16;

    localparam logic [OFFSET_W-1:0] OFFSET_LAST = 4'd9;
    localparam logic [2:0]          PHASE_LAST  = 3'd4;

    localparam logic [SYM_W-1:0] TOK_C0 = 10'h354;
    localparam logic [SYM_W-1:0] TOK_C1 = 10'h0AB;
    localparam logic [SYM_W-1:0] TOK_C2 = 10'h154;
    localparam logic [SYM_W-1:0] TOK_C3 = 10'h2AB;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lane_state_e;

    function automatic logic is_ctrl_token(input logic [SYM_W-1:0] sym);
        return (sym == TOK_C0) || (sym == TOK_C1) ||
               (sym == TOK_C2) || (sym == TOK_C3);
    endfunction

endpackage

// File: rtl/tmds_deser_1to10_if.sv
// Serial-side inputs and aligned-symbol outputs of the deserializer.
interface tmds_deser_1to10_if;
    import tmds_rx_pkg::*;

    logic [NUM_LANES-1:0]            din_h;
    logic [NUM_LANES-1:0]            din_l;
    logic [SYM_W-1:0]                data_b;
    logic [SYM_W-1:0]                data_g;
    logic [SYM_W-1:0]                data_r;
    logic                            word_valid;
    logic [NUM_LANES-1:0]            lane_locked;
    logic                            all_locked;
    logic [NUM_LANES*OFFSET_W-1:0]   slip_offset;

    modport master (
        output din_h, din_l,
        input  data_b, data_g, data_r, word_valid, lane_locked, all_locked, slip_offset
    );

    modport slave (
        input  din_h, din_l,
        output data_b, data_g, data_r, word_valid, lane_locked, all_locked, slip_offset
    );

endinterface

// File: rtl/tmds_lane_align.sv
// One TMDS lane: 20-bit bit history, offset window, control-token detector and
// SEARCH/LOCKED word-alignment FSM.
//
// state  | meaning
// SEARCH | hunting for LOCK_HITS consecutive tokens; slip one bit every SLIP_WAIT words
// LOCKED | alignment held; LOSS_WAIT consecutive non-tokens fall back to SEARCH
module tmds_lane_align
    import tmds_rx_pkg::*;
#(
    parameter int LOCK_HITS = 8,
    parameter int SLIP_WAIT = 4096,
    parameter int LOSS_WAIT = 4096
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                din_h_i,
    input  logic                din_l_i,
    input  logic                capture_i,
    input  logic                eval_i,
    output logic [SYM_W-1:0]    data_o,
    output logic                locked_o,
    output logic [OFFSET_W-1:0] offset_o
);

    logic [HIST_W-1:0]   hist_q, hist_d;
    logic [SYM_W-1:0]    data_q, data_d;
    logic [SYM_W-1:0]    window;

    lane_state_e         state_q, state_d;
    logic [CNT_W-1:0]    hit_q, hit_d;
    logic [CNT_W-1:0]    word_q, word_d;
    logic [CNT_W-1:0]    miss_q, miss_d;
    logic [OFFSET_W-1:0] offset_q, offset_d;

    logic                is_tok;
    logic [CNT_W-1:0]    hit_inc;
    logic [CNT_W-1:0]    word_inc;
    logic [CNT_W-1:0]    miss_inc;

    // Newest pair enters at the top, so lower indices are earlier on the wire.
    assign hist_d = {din_l_i, din_h_i, hist_q[HIST_W-1:2]};

    always_comb begin
        window = hist_d[SYM_W-1:0];
        for (int o = 0; o < NUM_OFFSETS; o++) begin
            if (offset_q == OFFSET_W'(o)) begin
                window = hist_d[o +: SYM_W];
            end
        end
    end

    assign data_d = capture_i ? window : data_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hist_q <= '0;
            data_q <= '0;
        end else begin
            hist_q <= hist_d;
            data_q <= data_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= SEARCH;
            hit_q    <= '0;
            word_q   <= '0;
            miss_q   <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            hit_q    <= hit_d;
            word_q   <= word_d;
            miss_q   <= miss_d;
            offset_q <= offset_d;
        end
    end

    assign is_tok   = is_ctrl_token(data_q);
    assign hit_inc  = hit_q + CNT_W'(1);
    assign word_inc = word_q + CNT_W'(1);
    assign miss_inc = miss_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        hit_d    = hit_q;
        word_d   = word_q;
        miss_d   = miss_q;
        offset_d = offset_q;
        if (eval_i) begin
            case (state_q)
                SEARCH: begin
                    hit_d  = is_tok ? hit_inc : '0;
                    word_d = word_inc;
                    // Lock takes priority over a slip landing on the same word.
                    if (is_tok && (hit_inc == CNT_W'(LOCK_HITS))) begin
                        state_d = LOCKED;
                        hit_d   = '0;
                        word_d  = '0;
                        miss_d  = '0;
                    end else if (word_inc == CNT_W'(SLIP_WAIT)) begin
                        offset_d = (offset_q == OFFSET_LAST) ? '0 : offset_q + OFFSET_W'(1);
                        hit_d    = '0;
                        word_d   = '0;
                    end
                end
                LOCKED: begin
                    if (is_tok) begin
                        miss_d = '0;
                    end else if (miss_inc == CNT_W'(LOSS_WAIT)) begin
                        state_d = SEARCH;
                        miss_d  = '0;
                        hit_d   = '0;
                        word_d  = '0;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
            endcase
        end
    end

    always_comb begin
        locked_o = (state_q == LOCKED);
    end

    assign data_o   = data_q;
    assign offset_o = offset_q;

endmodule

// File: rtl/tmds_deser_1to10.sv
// Three-lane TMDS 1:10 deserializer on the 5x clock: shared word phase plus
// per-lane bit alignment.
module tmds_deser_1to10
    import tmds_rx_pkg::*;
#(
    parameter int LOCK_HITS = 8,
    parameter int SLIP_WAIT = 4096,
    parameter int LOSS_WAIT = 4096
) (
    input  logic              clkx5,
    input  logic              rst,
    tmds_deser_1to10_if.slave bus
);

    logic [2:0]           phase_q, phase_d;
    logic                 word_end;
    logic                 word_valid_q, word_valid_d;

    logic [SYM_W-1:0]     lane_data   [NUM_LANES];
    logic [OFFSET_W-1:0]  lane_offset [NUM_LANES];
    logic [NUM_LANES-1:0] lane_locked;

    assign word_end     = (phase_q == PHASE_LAST);
    assign phase_d      = word_end ? 3'd0 : phase_q + 3'd1;
    assign word_valid_d = word_end;

    always_ff @(posedge clkx5 or posedge rst) begin
        if (rst) begin
            phase_q      <= '0;
            word_valid_q <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            word_valid_q <= word_valid_d;
        end
    end

    // Lanes capture on the last phase and judge the registered word one cycle later.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        tmds_lane_align #(
            .LOCK_HITS (LOCK_HITS),
            .SLIP_WAIT (SLIP_WAIT),
            .LOSS_WAIT (LOSS_WAIT)
        ) u_lane (
            .clk_i     (clkx5),
            .rst_i     (rst),
            .din_h_i   (bus.din_h[i]),
            .din_l_i   (bus.din_l[i]),
            .capture_i (word_end),
            .eval_i    (word_valid_q),
            .data_o    (lane_data[i]),
            .locked_o  (lane_locked[i]),
            .offset_o  (lane_offset[i])
        );
    end

    assign bus.data_b      = lane_data[0];
    assign bus.data_g      = lane_data[1];
    assign bus.data_r      = lane_data[2];
    assign bus.word_valid  = word_valid_q;
    assign bus.lane_locked = lane_locked;
    assign bus.all_locked  = &lane_locked;
    assign bus.slip_offset = {lane_offset[2], lane_offset[1], lane_offset[0]};

endmodule

// File: tb/tb_tmds_deser_1to10.sv
// Directed bench: builds per-lane wire bit streams, predicts each captured word,
// lock state and offset into a scoreboard, and checks them on word_valid.
module tb_tmds_deser_1to10;

    localparam int LOCK_HITS = 8;
    localparam int SLIP_WAIT = 16;
    localparam int LOSS_WAIT = 16;
    localparam logic [9:0] DATA_SYM = 10'h1F0;

    typedef struct packed {
        logic [9:0]  d_r;
        logic [9:0]  d_g;
        logic [9:0]  d_b;
        logic [2:0]  locked;
        logic [11:0] offset;
        logic [15:0] word;
    } exp_t;

    logic clkx5 = 1'b0;
    logic rst   = 1'b1;

    int   n_vec;
    int   n_err;
    int   t;
    int   scen;
    int   dly [3];
    logic [9:0] tok_sel [3];
    exp_t sb [$];

    tmds_deser_1to10_if bus ();

    tmds_deser_1to10 #(
        .LOCK_HITS (LOCK_HITS),
        .SLIP_WAIT (SLIP_WAIT),
        .LOSS_WAIT (LOSS_WAIT)
    ) dut (
        .clkx5 (clkx5),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clkx5 = ~clkx5;

    // Symbol m transmitted on a lane in the current scenario.
    function automatic logic [9:0] sym_at(input int lane, input int m);
        if (scen == 1 && m >= 20 && m < 36) return DATA_SYM;
        if (scen == 5 && (m % 8) == 7)      return DATA_SYM;
        return tok_sel[lane];
    endfunction

    // Wire bit b (2t on din_h, 2t+1 on din_l of cycle t after reset release).
    function automatic logic wire_bit(input int lane, input int b);
        int bb;
        logic [9:0] s;
        bb = b - dly[lane];
        if (bb < 0) return 1'b0;
        s = sym_at(lane, bb / 10);
        return s[bb % 10];
    endfunction

    function automatic logic [9:0] exp_data(input int lane, input int j, input int off);
        logic [9:0] w;
        for (int i = 0; i < 10; i++) w[i] = wire_bit(lane, 10 * j - 10 + off + i);
        return w;
    endfunction

    // Offset and lock seen while word j is presented, in closed form per scenario.
    task automatic exp_state(input int lane, input int j, output int off, output logic lk);
        int d;
        d = dly[lane];
        if (scen == 5) begin
            off = (j / 16) % 10;
            lk  = 1'b0;
        end else begin
            off = (d == 0) ? 0 : ((j >= 16 * d) ? d : j / 16);
            lk  = (d == 0) ? (j >= 9) : (j >= 16 * d + 8);
            if (scen == 1) lk = ((j >= 9) && (j < 37)) || (j >= 45);
        end
    endtask

    task automatic chk(input string tag, input int j, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s scen %0d word %0d: observed %0h expected %0h", tag, scen, j, obs, expv);
        end
    endtask

    task automatic step();
        exp_t e;
        int   off;
        logic lk;
        logic [2:0] dh;
        logic [2:0] dl;
        for (int ln = 0; ln < 3; ln++) begin
            dh[ln] = wire_bit(ln, 2 * t);
            dl[ln] = wire_bit(ln, 2 * t + 1);
        end
        bus.din_h = dh;
        bus.din_l = dl;
        if (t % 5 == 4) begin
            e.word = 16'(t / 5);
            exp_state(0, t / 5, off, lk);
            e.d_b = exp_data(0, t / 5, off); e.offset[3:0]  = 4'(off); e.locked[0] = lk;
            exp_state(1, t / 5, off, lk);
            e.d_g = exp_data(1, t / 5, off); e.offset[7:4]  = 4'(off); e.locked[1] = lk;
            exp_state(2, t / 5, off, lk);
            e.d_r = exp_data(2, t / 5, off); e.offset[11:8] = 4'(off); e.locked[2] = lk;
            sb.push_back(e);
        end
        @(posedge clkx5);
        #1;
        chk("word_valid", t / 5, 32'(bus.word_valid), (t % 5 == 4) ? 32'd1 : 32'd0);
        if (bus.word_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("data_b",      e.word, 32'(bus.data_b),      32'(e.d_b));
            chk("data_g",      e.word, 32'(bus.data_g),      32'(e.d_g));
            chk("data_r",      e.word, 32'(bus.data_r),      32'(e.d_r));
            chk("lane_locked", e.word, 32'(bus.lane_locked), 32'(e.locked));
            chk("all_locked",  e.word, 32'(bus.all_locked),  32'(&e.locked));
            chk("slip_offset", e.word, 32'(bus.slip_offset), 32'(e.offset));
        end
        t++;
    endtask

    task automatic run_words(input int n);
        repeat (5 * n) step();
    endtask

    task automatic do_reset();
        @(posedge clkx5);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_data_b",      t, 32'(bus.data_b),      32'd0);
        chk("rst_data_g",      t, 32'(bus.data_g),      32'd0);
        chk("rst_data_r",      t, 32'(bus.data_r),      32'd0);
        chk("rst_word_valid",  t, 32'(bus.word_valid),  32'd0);
        chk("rst_lane_locked", t, 32'(bus.lane_locked), 32'd0);
        chk("rst_all_locked",  t, 32'(bus.all_locked),  32'd0);
        chk("rst_slip_offset", t, 32'(bus.slip_offset), 32'd0);
        repeat (3) @(posedge clkx5);
        #1;
        rst = 1'b0;
        t   = 0;
        sb.delete();
    endtask

    task automatic end_scen();
        chk("sb_drained", t / 5, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        t     = 0;
        bus.din_h = '0;
        bus.din_l = '0;

        // Aligned lanes lock after 8 tokens, lose lock after 16 data words, relock.
        scen = 1;
        dly = '{0, 0, 0};
        tok_sel = '{10'h354, 10'h0AB, 10'h154};
        do_reset();
        run_words(50);
        end_scen();

        // Blue 3 bits late: slips 0->1->2->3 and locks there.
        scen = 2;
        dly = '{3, 0, 0};
        tok_sel = '{10'h354, 10'h354, 10'h354};
        do_reset();
        run_words(64);
        end_scen();

        // 9-bit delay: odd offset with bit 0 arriving on din_l.
        scen = 3;
        dly = '{9, 9, 9};
        do_reset();
        run_words(160);
        end_scen();

        // Lock at offset 5, then reset mid-frame and restart aligned.
        scen = 4;
        dly = '{5, 5, 5};
        do_reset();
        run_words(92);
        step();
        step();
        dly = '{0, 0, 0};
        tok_sel = '{10'h2AB, 10'h354, 10'h0AB};
        do_reset();
        run_words(12);
        end_scen();

        // Seven tokens then a data word: never locks, offset wraps 9->0.
        scen = 5;
        dly = '{0, 0, 0};
        tok_sel = '{10'h354, 10'h354, 10'h354};
        do_reset();
        run_words(180);
        end_scen();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
